dmem_slave_bank: RTL and testbench

Parametrised data-memory slave for the VeSPA SoC peripheral bus: a single-port-per-direction word memory with one write channel and one read channel, byte strobes, a configurable base address and depth, a hardware clear sequence after reset, and registered read data with a valid flag. It sits behind the bus interconnect as the data-memory peripheral. It replaces the fixed 32-bit data-memory slave with a block that also flags out-of-range, misaligned and busy-time accesses.

---
 rtl/dmem_slave_bank.sv | 131 +++++++++++++
 tb/tb_dmem_slave_bank.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/dmem_slave_bank.sv
// Word-addressed data-memory slave: byte-strobed writes, registered reads, range/alignment
// error reporting, and an optional zero-fill sweep of the whole array after reset.
module dmem_slave_bank #(
  parameter int                DATA_W         = 32,
  parameter int                ADDR_W         = 32,
  parameter int                DEPTH          = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR      = '0,
  parameter int                CLEAR_ON_RESET = 1
) (
  input  logic                   i_Clk,
  input  logic                   i_Rst,
  input  logic                   i_WEnable,
  input  logic [ADDR_W-1:0]      i_WAddr,
  input  logic [DATA_W-1:0]      i_WData,
  input  logic [DATA_W/8-1:0]    i_WStrb,
  input  logic                   i_REnable,
  input  logic [ADDR_W-1:0]      i_RAddr,
  output logic [DATA_W-1:0]      o_RData,
  output logic                   o_RValid,
  output logic                   o_Err,
  output logic                   o_MemBusy
);

  localparam int                BYTES      = DATA_W / 8;
  localparam int                LSB        = $clog2(BYTES);
  localparam int                IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]   BASE_EXT   = {1'b0, BASE_ADDR};
  localparam logic [ADDR_W:0]   SPAN_EXT   = (ADDR_W + 1)'(DEPTH * BYTES);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(BYTES - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(DEPTH - 1);

  typedef enum logic {ST_CLEAR, ST_READY} state_t;
  localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;

  state_t              r_state, w_state_next;
  logic [IDX_W-1:0]    r_clr_cnt, w_clr_cnt_next;
  logic [DATA_W-1:0]   r_mem [DEPTH];
  logic [DATA_W-1:0]   r_rdata;
  logic                r_rvalid, r_err;

  logic [ADDR_W:0]     w_woff, w_roff;
  logic                w_w_ok, w_r_ok, w_ready, w_wr, w_rd, w_err_next;
  logic [IDX_W-1:0]    w_widx, w_ridx;
  logic                w_mem_we;
  logic [IDX_W-1:0]    w_mem_idx;
  logic [DATA_W-1:0]   w_mem_data;
  logic [BYTES-1:0]    w_mem_strb;
  logic [BYTES-1:0]    w_lane_we;

  // Offsets are one bit wider than the bus so an address below the base shows up as a borrow.
  assign w_woff = {1'b0, i_WAddr} - BASE_EXT;
  assign w_roff = {1'b0, i_RAddr} - BASE_EXT;
  assign w_w_ok = ({1'b0, i_WAddr} >= BASE_EXT) && (w_woff < SPAN_EXT) &&
                  ((i_WAddr & ALIGN_MASK) == '0);
  assign w_r_ok = ({1'b0, i_RAddr} >= BASE_EXT) && (w_roff < SPAN_EXT) &&
                  ((i_RAddr & ALIGN_MASK) == '0);
  assign w_widx = w_woff[LSB +: IDX_W];
  assign w_ridx = w_roff[LSB +: IDX_W];

  assign w_ready    = (r_state == ST_READY);
  assign w_wr       = w_ready && i_WEnable && w_w_ok;
  assign w_rd       = w_ready && i_REnable && w_r_ok;
  assign w_err_next = w_ready ? ((i_WEnable && !w_w_ok) || (i_REnable && !w_r_ok))
                              : (i_WEnable || i_REnable);

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      r_state   <= RESET_STATE;
      r_clr_cnt <= '0;
    end else begin
      r_state   <= w_state_next;
      r_clr_cnt <= w_clr_cnt_next;
    end
  end

  // The clear sweep and bus writes share the single memory write port.
  always_comb begin
    w_state_next   = r_state;
    w_clr_cnt_next = r_clr_cnt;
    w_mem_we       = 1'b0;
    w_mem_idx      = w_widx;
    w_mem_data     = i_WData;
    w_mem_strb     = i_WStrb;
    case (r_state)
      ST_CLEAR: begin
        w_mem_we       = 1'b1;
        w_mem_idx      = r_clr_cnt;
        w_mem_data     = '0;
        w_mem_strb     = '1;
        w_clr_cnt_next = r_clr_cnt + 1'b1;
        if (r_clr_cnt == LAST_IDX) begin
          w_state_next   = ST_READY;
          w_clr_cnt_next = '0;
        end
      end
      default: w_mem_we = w_wr;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < BYTES; gi++) begin : g_lane
      assign w_lane_we[gi] = w_mem_we && w_mem_strb[gi];
    end
  endgenerate

  always_ff @(posedge i_Clk) begin
    for (int b = 0; b < BYTES; b++) begin
      if (w_lane_we[b]) r_mem[w_mem_idx][b*8 +: 8] <= w_mem_data[b*8 +: 8];
    end
  end

  // Same-edge read of a word being written returns the pre-write contents.
  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_rvalid <= w_ready && i_REnable;
      r_err    <= w_err_next;
      if (w_ready && i_REnable) r_rdata <= w_rd ? r_mem[w_ridx] : '0;
    end
  end

  assign o_RData   = r_rdata;
  assign o_RValid  = r_rvalid;
  assign o_Err     = r_err;
  assign o_MemBusy = (r_state == ST_CLEAR);

endmodule

// File: tb/tb_dmem_slave_bank.sv
// Directed plus randomized bench for dmem_slave_bank against a word-array reference model.
module tb_dmem_slave_bank;

  localparam int          DEPTH = 16;
  localparam int unsigned BASE  = 0;
  localparam int unsigned SPAN  = DEPTH * 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        we = 1'b0, re = 1'b0;
  logic [31:0] waddr = '0, wdata = '0, raddr = '0;
  logic [3:0]  wstrb = '0;
  logic [31:0] rdata;
  logic        rvalid, err, busy;

  int          tests_run = 0;
  int          tests_failed = 0;
  logic [31:0] model_mem [DEPTH];
  int          clear_left = 0;
  logic [31:0] exp_rdata = '0;

  always #5 clk = ~clk;

  dmem_slave_bank #(
    .DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH), .BASE_ADDR(32'(BASE)), .CLEAR_ON_RESET(1)
  ) dut (
    .i_Clk(clk), .i_Rst(rst_n),
    .i_WEnable(we), .i_WAddr(waddr), .i_WData(wdata), .i_WStrb(wstrb),
    .i_REnable(re), .i_RAddr(raddr),
    .o_RData(rdata), .o_RValid(rvalid), .o_Err(err), .o_MemBusy(busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests_run++;
    assert (obs === expv) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic bit addr_ok(input logic [31:0] a);
    return (a >= BASE) && ((a - BASE) < SPAN) && (a % 4 == 0);
  endfunction

  // One bus cycle: drive just after an edge, sample 1 time unit after the next edge.
  task automatic cycle(input logic w_en, input logic [31:0] w_a, input logic [31:0] w_d,
                       input logic [3:0] w_s, input logic r_en, input logic [31:0] r_a,
                       input string tag);
    bit was_busy, w_ok, r_ok, e_err, e_rvalid;
    we = w_en; waddr = w_a; wdata = w_d; wstrb = w_s; re = r_en; raddr = r_a;
    was_busy = (clear_left > 0);
    w_ok = addr_ok(w_a);
    r_ok = addr_ok(r_a);
    if (was_busy) begin
      e_err = w_en || r_en;
      e_rvalid = 1'b0;
    end else begin
      e_err = (w_en && !w_ok) || (r_en && !r_ok);
      e_rvalid = r_en;
      if (r_en) exp_rdata = r_ok ? model_mem[(r_a - BASE) / 4] : 32'h0;
    end
    @(posedge clk); #1;
    if (was_busy) begin
      clear_left--;
      if (clear_left == 0) for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    end else if (w_en && w_ok) begin
      for (int b = 0; b < 4; b++)
        if (w_s[b]) model_mem[(w_a - BASE) / 4][b*8 +: 8] = w_d[b*8 +: 8];
    end
    we = 1'b0; re = 1'b0;
    check({tag, ".rvalid"}, {31'b0, rvalid}, {31'b0, e_rvalid});
    check({tag, ".err"}, {31'b0, err}, {31'b0, e_err});
    check({tag, ".busy"}, {31'b0, busy}, {31'b0, clear_left > 0});
    if (e_rvalid) check({tag, ".rdata"}, rdata, exp_rdata);
    $display("[TB] %s we=%0b wa=%h wd=%h ws=%h re=%0b ra=%h -> rv=%0b rd=%h err=%0b busy=%0b",
             tag, w_en, w_a, w_d, w_s, r_en, r_a, rvalid, rdata, err, busy);
  endtask

  task automatic idle(input string tag);
    cycle(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, tag);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".rdata"}, rdata, 32'h0);
    check({tag, ".rvalid"}, {31'b0, rvalid}, 32'h0);
    check({tag, ".err"}, {31'b0, err}, 32'h0);
    check({tag, ".busy"}, {31'b0, busy}, 32'h1);
  endtask

  initial begin
    logic [31:0] a;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 'x;

    // Reset state, then release and watch the clear with one access landing mid-sweep.
    #2 check_reset_outputs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1; clear_left = DEPTH;
    idle("clr0"); idle("clr1");
    cycle(1'b1, 32'h14, 32'hDEADBEEF, 4'hF, 1'b1, 32'h14, "clr_access");
    for (int i = 3; i < DEPTH; i++) idle("clr");
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 0, 0, 0, 1'b1, 32'(BASE + i * 4), "rd_zero");

    // Write, read, byte strobes.
    cycle(1'b1, 32'h0, 32'hAA55AA55, 4'hF, 1'b0, 32'h0, "wr_full");
    cycle(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h0, "rd_full");
    idle("rv_pulse");
    cycle(1'b1, 32'h0, 32'h11223344, 4'h5, 1'b0, 32'h0, "wr_strb");
    cycle(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h0, "rd_strb");
    check("strb_literal", rdata, 32'hAA22AA44);
    cycle(1'b1, 32'h8, 32'h12345678, 4'h0, 1'b0, 32'h0, "wr_nostrb");

    // Errors: out-of-range write leaves memory alone, misaligned read returns zero.
    cycle(1'b1, 32'(BASE + SPAN), 32'hFFFFFFFF, 4'hF, 1'b0, 32'h0, "wr_oor");
    cycle(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h2, "rd_misal");
    cycle(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h0, "rd_after_oor");
    cycle(1'b1, 32'h6, 32'h1, 4'hF, 1'b1, 32'h4, "wr_misal_rd_ok");
    cycle(1'b1, 32'h4, 32'h7, 4'hF, 1'b1, 32'h100, "wr_ok_rd_oor");

    // Same-word read/write collision is read-first.
    cycle(1'b1, 32'hC, 32'h5, 4'hF, 1'b0, 32'h0, "wr_w3");
    cycle(1'b1, 32'hC, 32'h9, 4'hF, 1'b1, 32'hC, "collide");
    check("collide_old", rdata, 32'h5);
    cycle(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'hC, "collide_new");
    check("collide_new_lit", rdata, 32'h9);

    // Randomized traffic, biased towards legal aligned addresses.
    for (int n = 0; n < 300; n++) begin
      logic [31:0] wa, ra;
      wa = 32'($urandom_range(0, SPAN + 15));
      ra = 32'($urandom_range(0, SPAN + 15));
      if ($urandom_range(0, 3) != 0) begin wa = wa & ~32'h3; ra = ra & ~32'h3; end
      cycle(1'($urandom), wa, $urandom, 4'($urandom), 1'($urandom), ra, "rand");
    end

    // Asynchronous reset mid-traffic, then again mid-clear; the clear must restart in full.
    we = 1'b1; waddr = 32'h0; wdata = 32'hCAFEF00D; wstrb = 4'hF; re = 1'b1; raddr = 32'h0;
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async_rst");
    we = 1'b0; re = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1; clear_left = DEPTH;
    for (int i = 0; i < 7; i++) idle("clr_pre");
    rst_n = 1'b0;
    #1 check_reset_outputs("mid_clear_rst");
    @(posedge clk); #1;
    rst_n = 1'b1; clear_left = DEPTH;
    for (int i = 0; i < DEPTH; i++) idle("clr_restart");
    for (int i = 0; i < 4; i++) begin
      a = 32'(BASE + i * 4);
      cycle(1'b0, 0, 0, 0, 1'b1, a, "rd_after_restart");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
